button_enable_gen: RTL

Conditions a raw, bouncing, asynchronous push-button into the single-cycle `enable_i` pulse consumed by `counter_board`. Each debounced press produces exactly one pulse. A held button auto-repeats after a programmable delay, so the board counter advances one step per press, or steadily while the button is held. The block sits between the board pad buffer and `counter_board.enable_i`, in the same `clock_i` domain.

---
 rtl/button_enable_pkg.sv | 32 +++
 rtl/debounce_filter.sv | 54 +++++
 rtl/button_enable_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/button_enable_pkg.sv
// Shared types and helpers for the push-button enable generator.
// Holds the FSM state type, counter-width helpers and parameter legality.
package button_enable_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } state_t;

    // Debounce counter must hold DEBOUNCE_CYCLES-1 with headroom.
    function automatic int deb_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    // Repeat counter only ever reaches max(delay, period)-1.
    function automatic int rep_width(input int delay, input int period);
        int m;
        m = (delay > period) ? delay : period;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic bit params_legal(
        input int deb,
        input int delay,
        input int period
    );
        return (deb >= 1) &&
               ((delay == 0) || ((delay >= 2) && (period >= 2)));
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stable-count debounce filter.
// Ports: clock_i, reset_n_i (async low), raw_i (bouncy), level_o (clean).
module debounce_filter
    import button_enable_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int CW = deb_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Any cycle of agreement restarts the count, so only an unbroken
    // run of DEBOUNCE_CYCLES mismatching cycles flips the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_enable_gen.sv
// Turns a raw push-button into one enable pulse per press plus auto-repeat.
// Ports: clock_i, reset_n_i (async low), button_i, enable_o, pressed_o.
module button_enable_gen
    import button_enable_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic button_i,
    output logic enable_o,
    output logic pressed_o
);

    localparam int RW = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam bit REPEAT_EN = (REPEAT_DELAY != 0);
    localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

    if (!params_legal(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))
    begin : g_bad_params
        $error("button_enable_gen: illegal parameter combination");
    end

    logic          level;
    logic          prev_q;
    logic          rise;
    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          en_q;
    logic          en_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clock_i  (clock_i),
        .reset_n_i(reset_n_i),
        .raw_i    (button_i),
        .level_o  (level)
    );

    assign rise = level & ~prev_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev_q  <= 1'b0;
            state_q <= IDLE;
            rcnt_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            prev_q  <= level;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        en_d    = 1'b0;
        // Release wins over any terminal count in the same cycle.
        if (!level) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (rise) begin
                        en_d    = 1'b1;
                        state_d = REPEAT_EN ? HELD_DELAY : HELD_REPEAT;
                    end
                end
                HELD_DELAY: begin
                    if (rcnt_q == DELAY_TC) begin
                        en_d    = 1'b1;
                        rcnt_d  = '0;
                        state_d = HELD_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                HELD_REPEAT: begin
                    // With auto-repeat disabled this state just parks.
                    if (REPEAT_EN) begin
                        if (rcnt_q == PERIOD_TC) begin
                            en_d   = 1'b1;
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    assign enable_o  = en_q;
    assign pressed_o = level;

endmodule
